// File: rtl/fwd_pkg.sv
// fwd_pkg: shared definitions for the operand-forwarding unit.
//   FWD_SEL_RF       select code meaning "use the register-file value"
//   fwdEntryFlags_t  status part of one history entry (valid, pending)
//   fwdSelWidth()    width of a select code for a given history depth
//   fwdSatAdd32()    32-bit saturating add used by the statistics counters
package fwd_pkg;

  localparam int FWD_SEL_RF = 0;

  // Status flags of a history entry; address and data widths are set by the
  // instantiating module and wrapped around this struct there.
  typedef struct packed {
    logic valid;
    logic pending;
  } fwdEntryFlags_t;

  // Select codes span 0 (register file) plus one code per history entry.
  function automatic int fwdSelWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Add and clamp at the all-ones value instead of wrapping.
  function automatic logic [31:0] fwdSatAdd32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fwd_match.sv
// fwd_match: priority lookup of one source register against the write history.
//   rsAddr       source register address
//   histValid    per-entry valid flags (entry 0 youngest)
//   histPending  per-entry "result not yet available" flags
//   histAddr     per-entry destination addresses, entry i at [i*REG_AW +: REG_AW]
//   histData     per-entry result data, entry i at [i*DATA_W +: DATA_W]
//   rfData       register-file value used when nothing matches
//   sel          0 = register file, i+1 = history entry i
//   data         selected operand value
//   pending      selected producer has not delivered its result yet
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = fwdSelWidth(DEPTH)
) (
  input  logic [REG_AW-1:0]       rsAddr,
  input  logic [DEPTH-1:0]        histValid,
  input  logic [DEPTH-1:0]        histPending,
  input  logic [DEPTH*REG_AW-1:0] histAddr,
  input  logic [DEPTH*DATA_W-1:0] histData,
  input  logic [DATA_W-1:0]       rfData,
  output logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       data,
  output logic                    pending
);

  logic [DEPTH-1:0] hit_s;

  // Per-entry address compare; register 0 is hard-wired and never forwarded.
  always_comb begin
    hit_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      hit_s[i] = histValid[i] && (histAddr[i*REG_AW +: REG_AW] == rsAddr) &&
                 (rsAddr != {REG_AW{1'b0}});
    end
  end

  // Scan oldest to youngest so the youngest hit is the last one to override.
  always_comb begin
    sel     = SEL_W'(FWD_SEL_RF);
    data    = rfData;
    pending = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      sel     = hit_s[i] ? SEL_W'(i + 1) : sel;
      data    = hit_s[i] ? histData[i*DATA_W +: DATA_W] : data;
      pending = hit_s[i] ? histPending[i] : pending;
    end
  end

endmodule

// File: rtl/fwd_operand_unit.sv
// fwd_operand_unit: parametrised operand forwarding between register-file read
// and the ALU inputs. Keeps the last DEPTH register writes in a shift history,
// picks the youngest matching producer per operand and registers the result.
//   Clk, Rst_n         clock, asynchronous active-low reset
//   advance            pipeline advance; history shift and output update
//   flush              invalidate every history entry on the next edge
//   wr_*               write of the instruction entering stage 0
//   fill_valid/_data   late (load) data for history entry 1
//   rs_addr, rf_data   per-operand source addresses and register-file values
//   op_out, fwd_sel    registered operands and their select codes
//   stall              combinational load-use hazard
// Optional build macro FWD_STATS_EN adds saturating fwd_count / stall_count.
module fwd_operand_unit
  import fwd_pkg::*;
#(
  parameter int   DATA_W  = 32,
  parameter int   REG_AW  = 5,
  parameter int   DEPTH   = 3,
  parameter int   NUM_OPS = 2,
  localparam int  SEL_W   = fwdSelWidth(DEPTH)
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       advance,
  input  logic                       flush,
  input  logic                       wr_valid,
  input  logic [REG_AW-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_pending,
  input  logic                       fill_valid,
  input  logic [DATA_W-1:0]          fill_data,
  input  logic [NUM_OPS*REG_AW-1:0]  rs_addr,
  input  logic [NUM_OPS*DATA_W-1:0]  rf_data,
  output logic [NUM_OPS*DATA_W-1:0]  op_out,
  output logic [NUM_OPS*SEL_W-1:0]   fwd_sel,
`ifdef FWD_STATS_EN
  output logic [31:0]                fwd_count,
  output logic [31:0]                stall_count,
`endif
  output logic                       stall
);

  typedef struct packed {
    fwdEntryFlags_t      flags;
    logic [REG_AW-1:0]   addr;
    logic [DATA_W-1:0]   data;
  } histEntry_t;

  histEntry_t hist_r     [DEPTH];
  histEntry_t eff_s      [DEPTH];
  histEntry_t histNext_s [DEPTH];
  histEntry_t newEntry_s;

  logic [DEPTH-1:0]          effValid_s;
  logic [DEPTH-1:0]          effPending_s;
  logic [DEPTH*REG_AW-1:0]   effAddr_s;
  logic [DEPTH*DATA_W-1:0]   effData_s;

  logic [NUM_OPS*SEL_W-1:0]  selNext_s;
  logic [NUM_OPS*DATA_W-1:0] opNext_s;
  logic [NUM_OPS-1:0]        opPending_s;

  // Late load data patches entry 1 before lookup and before any shift.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      eff_s[i] = hist_r[i];
    end
    if (fill_valid) begin
      eff_s[1].data          = fill_data;
      eff_s[1].flags.pending = 1'b0;
    end else begin
      eff_s[1] = hist_r[1];
    end
  end

  // Flatten the patched history for the per-operand matchers.
  always_comb begin
    effValid_s   = {DEPTH{1'b0}};
    effPending_s = {DEPTH{1'b0}};
    effAddr_s    = {(DEPTH*REG_AW){1'b0}};
    effData_s    = {(DEPTH*DATA_W){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      effValid_s[i]                  = eff_s[i].flags.valid;
      effPending_s[i]                = eff_s[i].flags.pending;
      effAddr_s[i*REG_AW +: REG_AW]  = eff_s[i].addr;
      effData_s[i*DATA_W +: DATA_W]  = eff_s[i].data;
    end
  end

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_match
    fwd_match #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .SEL_W  (SEL_W)
    ) u_match (
      .rsAddr      (rs_addr[k*REG_AW +: REG_AW]),
      .histValid   (effValid_s),
      .histPending (effPending_s),
      .histAddr    (effAddr_s),
      .histData    (effData_s),
      .rfData      (rf_data[k*DATA_W +: DATA_W]),
      .sel         (selNext_s[k*SEL_W +: SEL_W]),
      .data        (opNext_s[k*DATA_W +: DATA_W]),
      .pending     (opPending_s[k])
    );
  end

  assign stall = |opPending_s;

  // Stage-0 entry: a stall or flush inserts a bubble instead of the new write.
  always_comb begin
    newEntry_s.flags.valid   = wr_valid && !stall && !flush;
    newEntry_s.flags.pending = wr_pending && wr_valid;
    newEntry_s.addr          = wr_addr;
    newEntry_s.data          = wr_data;
  end

  // Next history: shift on advance, otherwise hold (fill still lands), flush clears valid.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      histNext_s[i] = eff_s[i];
    end
    if (advance) begin
      histNext_s[0] = newEntry_s;
      for (int i = 1; i < DEPTH; i++) begin
        histNext_s[i] = eff_s[i-1];
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        histNext_s[i] = eff_s[i];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      histNext_s[i].flags.valid = histNext_s[i].flags.valid && !flush;
    end
  end

  // History register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_r[i] <= histNext_s[i];
      end
    end
  end

  // Operand/select outputs update only on a clean advance; stall and flush hold them.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_out  <= {(NUM_OPS*DATA_W){1'b0}};
      fwd_sel <= {(NUM_OPS*SEL_W){1'b0}};
    end else if (advance && !stall && !flush) begin
      op_out  <= opNext_s;
      fwd_sel <= selNext_s;
    end else begin
      op_out  <= op_out;
      fwd_sel <= fwd_sel;
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] fwdOps_s;

  // Number of operands taken from the history this cycle.
  always_comb begin
    fwdOps_s = 32'd0;
    for (int k = 0; k < NUM_OPS; k++) begin
      fwdOps_s = fwdOps_s + {31'd0, (selNext_s[k*SEL_W +: SEL_W] != {SEL_W{1'b0}})};
    end
  end

  // Saturating statistics counters; only reset clears them.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fwd_count   <= 32'd0;
      stall_count <= 32'd0;
    end else if (advance && !stall) begin
      fwd_count   <= fwdSatAdd32(fwd_count, fwdOps_s);
      stall_count <= stall_count;
    end else if (advance && stall) begin
      fwd_count   <= fwd_count;
      stall_count <= fwdSatAdd32(stall_count, 32'd1);
    end else begin
      fwd_count   <= fwd_count;
      stall_count <= stall_count;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_operand_unit.sv
// tb_fwd_operand_unit: directed-vector bench for fwd_operand_unit at default
// parameters (DATA_W=32, REG_AW=5, DEPTH=3, NUM_OPS=2, select width 2).
// Operand 0 sits in the low slice of every packed bus.
module tb_fwd_operand_unit;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        advance = 1'b0;
  logic        flush = 1'b0;
  logic        wr_valid = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_pending = 1'b0;
  logic        fill_valid = 1'b0;
  logic [31:0] fill_data = 32'd0;
  logic [9:0]  rs_addr = 10'd0;
  logic [63:0] rf_data = 64'd0;
  logic [63:0] op_out;
  logic [3:0]  fwd_sel;
  logic        stall;
`ifdef FWD_STATS_EN
  logic [31:0] fwd_count;
  logic [31:0] stall_count;
`endif

  int checkCount = 0;
  int errorCount = 0;

  fwd_operand_unit u_dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .advance    (advance),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_pending (wr_pending),
    .fill_valid (fill_valid),
    .fill_data  (fill_data),
    .rs_addr    (rs_addr),
    .rf_data    (rf_data),
    .op_out     (op_out),
    .fwd_sel    (fwd_sel),
`ifdef FWD_STATS_EN
    .fwd_count  (fwd_count),
    .stall_count(stall_count),
`endif
    .stall      (stall)
  );

  always #5 Clk = ~Clk;

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic setOps(input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
    rs_addr = {a1, a0};
    rf_data = {d1, d0};
  endtask

  task automatic setWrite(input logic v, input logic [4:0] a, input logic [31:0] d, input logic p);
    wr_valid   = v;
    wr_addr    = a;
    wr_data    = d;
    wr_pending = p;
  endtask

  initial begin
    // Reset
    #1 Rst_n = 1'b0;
    #2;
    checkValue("reset_op_out", op_out, 64'd0);
    checkValue("reset_fwd_sel", {60'd0, fwd_sel}, 64'd0);
    checkValue("reset_stall", {63'd0, stall}, 64'd0);
    tick();
    Rst_n = 1'b1;

    // Empty history: register-file values pass through
    advance = 1'b1;
    setOps(5'd3, 5'd4, 32'h11, 32'h22);
    tick();
    checkValue("rf_pass_op", op_out, {32'h22, 32'h11});
    checkValue("rf_pass_sel", {60'd0, fwd_sel}, 64'd0);

    // r3=AAAA enters entry 0; lookup in the same cycle still sees the RF
    setWrite(1'b1, 5'd3, 32'hAAAA, 1'b0);
    tick();
    checkValue("same_cycle_rf", op_out, {32'h22, 32'h11});
    // r3=BBBB enters; lookup hits entry 0 (AAAA)
    setWrite(1'b1, 5'd3, 32'hBBBB, 1'b0);
    tick();
    checkValue("fwd_e0_op", op_out, {32'h22, 32'hAAAA});
    checkValue("fwd_e0_sel", {60'd0, fwd_sel}, {60'd0, 2'd0, 2'd1});
    // Both ops read r3: entry 0 (BBBB) beats entry 1 (AAAA)
    setWrite(1'b0, 5'd0, 32'd0, 1'b0);
    setOps(5'd3, 5'd3, 32'h11, 32'h11);
    tick();
    checkValue("youngest_op", op_out, {32'hBBBB, 32'hBBBB});
    checkValue("youngest_sel", {60'd0, fwd_sel}, {60'd0, 2'd1, 2'd1});
    // BBBB now in entry 1
    setOps(5'd3, 5'd4, 32'h11, 32'h22);
    tick();
    checkValue("fwd_e1_op", op_out, {32'h22, 32'hBBBB});
    checkValue("fwd_e1_sel", {60'd0, fwd_sel}, {60'd0, 2'd0, 2'd2});

    // Load r5 (pending) enters entry 0
    setWrite(1'b1, 5'd5, 32'hDEAD, 1'b1);
    setOps(5'd1, 5'd2, 32'h1, 32'h2);
    tick();
    checkValue("pre_load_op", op_out, {32'h2, 32'h1});
    // Load-use: stall, outputs hold, bubble enters
    setWrite(1'b0, 5'd0, 32'd0, 1'b0);
    setOps(5'd5, 5'd2, 32'h55, 32'h2);
    #1;
    checkValue("load_use_stall", {63'd0, stall}, 64'd1);
    tick();
    checkValue("stall_hold_op", op_out, {32'h2, 32'h1});
    checkValue("stall_hold_sel", {60'd0, fwd_sel}, 64'd0);
    checkValue("stall_e1_pending", {63'd0, stall}, 64'd1);
    // Fill entry 1 clears the hazard this cycle
    fill_valid = 1'b1;
    fill_data  = 32'h1234;
    #1;
    checkValue("fill_clears_stall", {63'd0, stall}, 64'd0);
    tick();
    checkValue("fill_op", op_out, {32'h2, 32'h1234});
    checkValue("fill_sel", {60'd0, fwd_sel}, {60'd0, 2'd0, 2'd2});
    // Filled data shifted into entry 2
    fill_valid = 1'b0;
    fill_data  = 32'd0;
    tick();
    checkValue("fill_e2_op", op_out, {32'h2, 32'h1234});
    checkValue("fill_e2_sel", {60'd0, fwd_sel}, {60'd0, 2'd0, 2'd3});

    // Register 0 is never forwarded and never stalls
    setOps(5'd1, 5'd2, 32'h1, 32'h2);
    setWrite(1'b1, 5'd0, 32'hFFFF, 1'b0);
    tick();
    setWrite(1'b1, 5'd0, 32'hFFFF, 1'b1);
    tick();
    setWrite(1'b0, 5'd0, 32'd0, 1'b0);
    setOps(5'd0, 5'd0, 32'd0, 32'd0);
    #1;
    checkValue("r0_no_stall", {63'd0, stall}, 64'd0);
    tick();
    checkValue("r0_op", op_out, 64'd0);
    checkValue("r0_sel", {60'd0, fwd_sel}, 64'd0);

    // Flush drops r7 and dominates a same-cycle write; outputs hold
    setOps(5'd1, 5'd2, 32'h1, 32'h2);
    setWrite(1'b1, 5'd7, 32'h7777, 1'b0);
    tick();
    flush = 1'b1;
    setWrite(1'b1, 5'd7, 32'h8888, 1'b0);
    setOps(5'd3, 5'd4, 32'h33, 32'h44);
    tick();
    checkValue("flush_hold_op", op_out, {32'h2, 32'h1});
    flush = 1'b0;
    setWrite(1'b0, 5'd0, 32'd0, 1'b0);
    setOps(5'd7, 5'd7, 32'h70, 32'h71);
    tick();
    checkValue("flush_rf_op", op_out, {32'h71, 32'h70});
    checkValue("flush_rf_sel", {60'd0, fwd_sel}, 64'd0);

    // Asynchronous reset mid-stream clears outputs and history at once
    setWrite(1'b1, 5'd9, 32'h9999, 1'b0);
    tick();
    Rst_n = 1'b0;
    #2;
    checkValue("async_rst_op", op_out, 64'd0);
    checkValue("async_rst_sel", {60'd0, fwd_sel}, 64'd0);
    #1 Rst_n = 1'b1;
    setWrite(1'b0, 5'd0, 32'd0, 1'b0);
    setOps(5'd9, 5'd0, 32'h90, 32'd0);
    tick();
    checkValue("post_rst_op", op_out, {32'd0, 32'h90});
    checkValue("post_rst_sel", {60'd0, fwd_sel}, 64'd0);

`ifdef FWD_STATS_EN
    // Two forwarded operands, then one stalled advance
    setWrite(1'b1, 5'd10, 32'hA0, 1'b0);
    tick();
    setWrite(1'b1, 5'd11, 32'd0, 1'b1);
    setOps(5'd10, 5'd10, 32'd0, 32'd0);
    tick();
    setWrite(1'b0, 5'd0, 32'd0, 1'b0);
    setOps(5'd11, 5'd0, 32'd0, 32'd0);
    tick();
    checkValue("stats_fwd", {32'd0, fwd_count}, 64'd2);
    checkValue("stats_stall", {32'd0, stall_count}, 64'd1);
`endif

    advance = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fwd_operand_unit.md
# fwd_operand_unit

Parametrised operand-forwarding unit for the pipelined datapath; successor to the fixed 3-to-1 forwarding mux. Tracks the last DEPTH in-flight register writes in a shift history, selects per operand the youngest matching producer, else the register-file value, and registers the chosen operand. Detects load-use hazards and raises stall when the youngest match is still pending. Sits between ID/EX register-file read and the ALU operand inputs.

## Interface
- DATA_W, 32, operand/data width
- REG_AW, 5, register address width
- DEPTH, 3, number of tracked in-flight write stages (2..8)
- NUM_OPS, 2, number of source operands looked up per cycle
- SEL_W, $clog2(DEPTH+1), width of each select code

- Clk  in  1  rising-edge clock
- Rst_n  in  1  reset, asynchronous, active-low
- advance  in  1  pipeline advance enable; history and outputs update only when 1
- flush  in  1  invalidate all history entries
- wr_valid  in  1  instruction entering stage 0 writes a register
- wr_addr  in  REG_AW  destination register
- wr_data  in  DATA_W  result value (ignored if wr_pending)
- wr_pending  in  1  result not yet available (load)
- fill_valid  in  1  late data for history entry 1 is present
- fill_data  in  DATA_W  late (load) data
- rs_addr  in  NUM_OPS*REG_AW  source register addresses, op k at bits [k*REG_AW +: REG_AW]
- rf_data  in  NUM_OPS*DATA_W  register-file read values
- op_out  out  NUM_OPS*DATA_W  registered selected operands
- fwd_sel  out  NUM_OPS*SEL_W  registered selection: 0 = register file, i+1 = history entry i
- stall  out  1  combinational load-use hazard indication

## Operation
- History entry i holds {valid, addr, data, pending}; entry 0 youngest.
- Match for op k: entry i valid, addr == rs_addr[k], rs_addr[k] != 0. Youngest matching entry wins; none → rf_data[k], sel 0.
- stall = 1 if any op's winning entry has pending = 1 (after same-cycle fill is applied to entry 1).
- Fill: fill_valid writes fill_data into entry 1 and clears its pending, this cycle; applied before any shift, so with advance the data lands in entry 2.
- advance=1, stall=0: entry i ← entry i-1; entry 0 ← {wr_valid, wr_addr, wr_data, wr_pending}; op_out/fwd_sel ← current selection.
- advance=1, stall=1: history shifts, entry 0 ← bubble (valid=0); op_out/fwd_sel hold; caller holds its instruction.
- advance=0: history holds (fill still applies); outputs hold.
- flush (any advance): all valid ← 0 next edge; op_out/fwd_sel hold; flush dominates wr_valid.
- Entry DEPTH-1 falls off on shift; writes beyond DEPTH stages are assumed committed to the register file.
- Register 0 never forwarded, never stalls.

## Timing
- Reset (Rst_n low, async): all history valid=0, pending=0, data=0; op_out=0; fwd_sel=0; stall=0 as consequence.
- Lookup combinational from history + fill; op_out registered: 1-cycle latency from rs_addr to op_out.
- Reset asserted mid-operation clears history immediately; first post-reset advance behaves as empty history.
- fill_valid with entry 1 not pending: data overwrites, no other effect.

## Configuration
- FWD_STATS_EN defined: adds outputs fwd_count[31:0] and stall_count[31:0]; fwd_count increments by number of ops with sel != 0 on each advance without stall; stall_count increments each cycle advance=1 and stall=1; both saturate at 2^32-1, reset to 0, unaffected by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package fwd_pkg: FWD_SEL_RF = 0 constant, history entry struct typedef, sel-width helper function.
- Sub-module fwd_match: one per operand (generate), priority compare of one rs_addr against history, returns sel, data, pending.

## Test plan
- Reset, rs_addr={r3,r4}, rf_data={0x11,0x22}, advance → op_out={0x11,0x22}, fwd_sel={0,0}.
- Write r3=0xAAAA in entry 0, next lookup r3 → op_out=0xAAAA, sel=1; same r3 written again with 0xBBBB → 0xBBBB, sel=1 (youngest wins over entry 1).
- Load r5 pending, next cycle rs=r5 → stall=1, bubble shifts in; fill_data=0x1234 into entry 1 → stall=0, op_out=0x1234, sel=3 after advance.
- Write r0=0xFFFF, lookup r0 with rf_data=0 → op_out=0, sel=0, stall=0.
- Write r7, flush, lookup r7 → sel=0, rf value used; Rst_n pulse mid-stream → op_out=0 immediately.
- With FWD_STATS_EN: two forwarded ops + one stall cycle → fwd_count=2, stall_count=1.
